// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (priority) and a debug read port.
// Optional macro DMEM_ARB_STARVE_EN enables the bounded-starvation forced debug grant.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, D_WAIT, D_READ, D_ACK} state_t;

  state_t r_state, w_state_nxt;
  logic   w_dreq, w_grant, w_stall;

  // While reset is held the request is masked so the port stays with the pipeline.
  assign w_dreq = d_req & reset;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);
  logic [3:0] r_wait_cnt, w_wait_cnt_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_stall     = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_dreq && !p_req) begin
          w_grant     = 1'b1;
          w_state_nxt = D_READ;
        end else if (w_dreq) begin
`ifdef DMEM_ARB_STARVE_EN
          w_wait_cnt_nxt = 4'd1;
`endif
          w_state_nxt = D_WAIT;
        end
      end
      D_WAIT: begin
        if (!w_dreq) begin
`ifdef DMEM_ARB_STARVE_EN
          w_wait_cnt_nxt = 4'd0;
`endif
          w_state_nxt = IDLE;
        end else if (!p_req) begin
          w_grant     = 1'b1;
          w_state_nxt = D_READ;
        end
`ifdef DMEM_ARB_STARVE_EN
        else if (r_wait_cnt == STARVE_CNT) begin
          w_grant     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = D_READ;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end
`endif
      end
      D_READ: w_state_nxt = D_ACK;
      D_ACK: begin
`ifdef DMEM_ARB_STARVE_EN
        w_wait_cnt_nxt = 4'd0;
`endif
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      d_rdata <= '0;
`ifdef DMEM_ARB_STARVE_EN
      r_wait_cnt <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
`ifdef DMEM_ARB_STARVE_EN
      r_wait_cnt <= w_wait_cnt_nxt;
`endif
      // Memory returns the granted word during D_READ.
      if (r_state == D_READ) d_rdata <= mem_rdata;
    end
  end

  assign d_ack     = (r_state == D_ACK);
  assign p_stall   = w_stall;
  assign p_rdata   = mem_rdata;
  assign mem_addr  = w_grant ? d_addr : p_addr;
  assign mem_wdata = p_wdata;
  assign mem_we    = ~w_grant & p_we & p_req & ~w_stall;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference model; follows DMEM_ARB_STARVE_EN like the design.
module tb_dmem_arbiter;
  localparam int SMAX = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clock, reset, p_req, p_we, p_stall, d_req, d_ack, mem_we;
  logic [31:0] p_addr, p_wdata, p_rdata, d_addr, d_rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset), .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_stall(p_stall), .d_req(d_req),
    .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory attached to the port: read-first, one cycle read latency.
  logic [31:0] tbmem [64];
  always @(posedge clock) begin
    if (mem_we) tbmem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= tbmem[mem_addr[5:0]];
  end

  typedef struct {
    int          cyc;
    logic        stall, we, ack, prd_v;
    logic [31:0] addr, wdata, rdata, prd;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, cyc = 0;
  int last_ack_cyc = -1, last_stall_cyc = -1;
  logic [31:0] last_ack_data = '0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h", name, c, act, exp);
    end
  endtask

  // Reference model: a debug request waits from its start cycle until the pipeline is idle,
  // or (starvation enabled) until SMAX cycles have passed; data is returned two cycles after grant.
  logic [31:0] mmem [64];
  int          m_start = -1, m_grant = -1;
  logic [31:0] m_gdata = '0, m_last = '0, m_prd = '0;
  bit          m_prd_v = 1'b0, txn_done = 1'b0;

  task automatic step(input bit rst, input bit pr, input bit pw, input logic [31:0] pa,
                      input logic [31:0] pd, input bit dr, input logic [31:0] da);
    exp_t e;
    bit   grant, forced, ack;
    @(negedge clock);
    reset = rst; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd; d_req = dr; d_addr = da;
    grant = 1'b0; forced = 1'b0; ack = 1'b0;
    if (!rst) begin
      m_start = -1; m_grant = -1; m_last = '0;
    end else if (m_grant >= 0) begin
      if (cyc == m_grant + 2) begin
        ack = 1'b1; m_last = m_gdata; m_grant = -1; txn_done = 1'b1;
      end
    end else if (dr) begin
      if (m_start < 0) m_start = cyc;
      if (!pr) grant = 1'b1;
      else if (STARVE && (cyc - m_start == SMAX)) begin grant = 1'b1; forced = 1'b1; end
      if (grant) begin m_grant = cyc; m_gdata = mmem[da[5:0]]; m_start = -1; end
    end else begin
      m_start = -1;
    end
    e.cyc = cyc; e.stall = forced; e.ack = ack; e.rdata = m_last;
    e.addr = grant ? da : pa;
    e.we = !grant && pr && pw;
    e.wdata = pd;
    e.prd = m_prd; e.prd_v = m_prd_v;
    q.push_back(e);
    m_prd = mmem[e.addr[5:0]]; m_prd_v = 1'b1;
    if (e.we) mmem[pa[5:0]] = pd;
    cyc++;
  endtask

  // Monitor: pops one expectation per cycle and compares the DUT's outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("p_stall", e.cyc, 32'(p_stall), 32'(e.stall));
        chk("mem_we", e.cyc, 32'(mem_we), 32'(e.we));
        chk("mem_addr", e.cyc, mem_addr, e.addr);
        chk("d_ack", e.cyc, 32'(d_ack), 32'(e.ack));
        chk("d_rdata", e.cyc, d_rdata, e.rdata);
        if (e.we) chk("mem_wdata", e.cyc, mem_wdata, e.wdata);
        if (e.prd_v) chk("p_rdata", e.cyc, p_rdata, e.prd);
        if (d_ack === 1'b1) begin last_ack_cyc = e.cyc; last_ack_data = d_rdata; end
        if (p_stall === 1'b1) last_stall_cyc = e.cyc;
      end
    end
  end

  initial begin
    int t0, ack0, stall0;
    bit dr, heavy;
    logic [31:0] da;
    for (int i = 0; i < 64; i++) begin
      tbmem[i] = 32'h1000_0000 + i * 32'h0101;
      mmem[i]  = tbmem[i];
    end
    tbmem[16] = 32'hDEAD_BEEF; mmem[16] = 32'hDEAD_BEEF;
    reset = 1'b0; p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; d_req = 1'b0; d_addr = '0;

    // Reset with a pending debug request: memory driven from the pipeline.
    step(0, 1, 1, 32'h3, 32'h11, 1, 32'h10);
    step(0, 0, 0, 32'h4, 32'h22, 1, 32'h10);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    // Idle pipeline debug read of 0x10.
    t0 = cyc;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1, 32'h10);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #3;
    chk("idle_ack_lat", t0, 32'(last_ack_cyc - t0), 32'd2);
    chk("idle_ack_data", t0, last_ack_data, 32'hDEAD_BEEF);

    // Continuous pipeline traffic with stores; p_req drops at relative cycle 10.
    t0 = cyc; stall0 = last_stall_cyc; txn_done = 1'b0;
    for (int i = 0; i < 30 && !txn_done; i++) step(1, i < 10, 1, 32'h30 + i, 32'hA000 + i, 1, 32'h08);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #3;
    chk("starve_ack_lat", t0, 32'(last_ack_cyc - t0), STARVE ? 32'd6 : 32'd12);
    chk("starve_stall_at", t0, 32'(last_stall_cyc - t0), STARVE ? 32'd4 : 32'(stall0 - t0));

    // Pipeline store in the D_READ cycle, then read it back.
    step(1, 0, 0, 32'h0, 32'h0, 1, 32'h05);
    step(1, 1, 1, 32'h20, 32'h55, 1, 32'h05);
    step(1, 0, 0, 32'h0, 32'h0, 1, 32'h05);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1, 32'h20);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #3;
    chk("store_readback", cyc, last_ack_data, 32'h55);

    // Reset during D_READ: the read restarts once reset is released.
    t0 = cyc;
    step(1, 0, 0, 32'h0, 32'h0, 1, 32'h11);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h11);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1, 32'h11);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #3;
    chk("rst_restart_ack", t0, 32'(last_ack_cyc - t0), 32'd4);

    // Request withdrawn while waiting: no grant, no stall, no ack.
    ack0 = last_ack_cyc; stall0 = last_stall_cyc;
    step(1, 1, 0, 32'h1, 32'h0, 1, 32'h12);
    step(1, 1, 0, 32'h2, 32'h0, 1, 32'h12);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h3 + i, 32'h0, 0, 32'h0);
    #3;
    chk("abort_no_ack", cyc, 32'(last_ack_cyc), 32'(ack0));
    chk("abort_no_stall", cyc, 32'(last_stall_cyc), 32'(stall0));

    // Randomized traffic.
    dr = 1'b0; da = '0; heavy = 1'b0; txn_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 32 == 0) heavy = $urandom_range(0, 1) == 1;
      if (!dr) begin
        if ($urandom_range(0, 3) == 0) begin dr = 1'b1; da = 32'($urandom_range(0, 63)); end
      end else if (txn_done) begin
        txn_done = 1'b0;
        if ($urandom_range(0, 1) == 1) dr = 1'b0;
      end else if (m_start >= 0 && m_grant < 0 && $urandom_range(0, 15) == 0) begin
        dr = 1'b0;
      end
      step($urandom_range(0, 299) != 0,
           heavy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1),
           $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom, dr, da);
    end
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #3;
    chk("sb_drain", cyc, 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
